player_ctrl: RTL



---
 rtl/player_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/player_ctrl.sv
// Player ship controller: accelerating movement with clamp (or wrap when
// PLAYER_WRAP_EN is defined), fire cooldown arbitration and a hit/lives/respawn FSM.
module player_ctrl #(
    parameter int COORD_W       = 10,
    parameter int START_X       = 304,
    parameter int START_Y       = 440,
    parameter int MIN_X         = 0,
    parameter int MAX_X         = 608,
    parameter int STEP_MIN      = 1,
    parameter int STEP_MAX      = 4,
    parameter int ACCEL_FRAMES  = 8,
    parameter int FIRE_COOLDOWN = 30,
    parameter int LIVES         = 3,
    parameter int LIVES_W       = 3,
    parameter int DEATH_FRAMES  = 32,
    parameter int INVULN_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame,
    input  logic               left,
    input  logic               right,
    input  logic               fire,
    input  logic               shot_busy,
    input  logic               hit,
    output logic [COORD_W-1:0] player_x,
    output logic [COORD_W-1:0] player_y,
    output logic               fire_pulse,
    output logic [LIVES_W-1:0] lives,
    output logic               alive,
    output logic               visible,
    output logic               game_over,
    output logic [1:0]         dbg_state
);

    localparam int CW1     = COORD_W + 1;
    localparam int SPD_W   = $clog2(STEP_MAX + 1);
    localparam int HOLD_W  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam int CD_W    = $clog2(FIRE_COOLDOWN + 1);
    localparam int TMR_MAX = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
    localparam int TMR_W   = ($clog2(TMR_MAX) < 3) ? 3 : $clog2(TMR_MAX);

    localparam logic [COORD_W-1:0] START_X_C  = COORD_W'(START_X);
    localparam logic [SPD_W-1:0]   STEP_MIN_C = SPD_W'(STEP_MIN);
    localparam logic [SPD_W-1:0]   STEP_MAX_C = SPD_W'(STEP_MAX);
    localparam logic [HOLD_W-1:0]  HOLD_TOP_C = HOLD_W'(ACCEL_FRAMES - 1);
    localparam logic [CD_W-1:0]    COOL_C     = CD_W'(FIRE_COOLDOWN);
    localparam logic [TMR_W-1:0]   DEATH_C    = TMR_W'(DEATH_FRAMES - 1);
    localparam logic [TMR_W-1:0]   INVULN_C   = TMR_W'(INVULN_FRAMES - 1);
    localparam logic [CW1-1:0]     MIN_X_E    = CW1'(MIN_X);
    localparam logic [CW1-1:0]     MAX_X_E    = CW1'(MAX_X);

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_DYING     = 2'd1,
        ST_RESPAWN   = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    // Direction encoding: bit0 = left, bit1 = right, 00 = none.
    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SPD_W-1:0]   speed_q, speed_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]         dir_q, dir_d;
    logic [CD_W-1:0]    cool_q, cool_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               hit_pend_q, hit_pend_d;
    logic               fire_pulse_q, fire_pulse_d;

    logic               can_act;
    logic [1:0]         dir_now;
    logic [CW1-1:0]     x_ext, spd_ext, lo_lim, sum_r;

    assign can_act = (state_q == ST_ALIVE) || (state_q == ST_RESPAWN);
    assign dir_now = {right & ~left, left & ~right};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ALIVE;
            x_q          <= START_X_C;
            lives_q      <= LIVES_W'(LIVES);
            speed_q      <= STEP_MIN_C;
            hold_q       <= '0;
            dir_q        <= 2'b00;
            cool_q       <= '0;
            timer_q      <= '0;
            hit_pend_q   <= 1'b0;
            fire_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            lives_q      <= lives_d;
            speed_q      <= speed_d;
            hold_q       <= hold_d;
            dir_q        <= dir_d;
            cool_q       <= cool_d;
            timer_q      <= timer_d;
            hit_pend_q   <= hit_pend_d;
            fire_pulse_q <= fire_pulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        lives_d      = lives_q;
        speed_d      = speed_q;
        hold_d       = hold_q;
        dir_d        = dir_q;
        cool_d       = cool_q;
        timer_d      = timer_q;
        hit_pend_d   = hit_pend_q;
        fire_pulse_d = 1'b0;
        x_ext        = {1'b0, x_q};
        spd_ext      = '0;
        lo_lim       = '0;
        sum_r        = '0;

        // A hit arriving on the very frame that consumes a pending hit is dropped:
        // the ship is already on its way to DYING.
        if (frame && hit_pend_q) begin
            hit_pend_d = 1'b0;
        end else if (hit && (state_q == ST_ALIVE)) begin
            hit_pend_d = 1'b1;
        end

        if (frame) begin
            if (fire && can_act && (cool_q == '0) && !shot_busy) begin
                fire_pulse_d = 1'b1;
                cool_d       = COOL_C;
            end else if (cool_q != '0) begin
                cool_d = cool_q - CD_W'(1);
            end

            if (can_act) begin
                dir_d = dir_now;
                if ((dir_now == 2'b00) || (dir_now != dir_q)) begin
                    speed_d = STEP_MIN_C;
                    hold_d  = '0;
                end else if (hold_q == HOLD_TOP_C) begin
                    hold_d  = '0;
                    speed_d = (speed_q < STEP_MAX_C) ? speed_q + SPD_W'(1) : speed_q;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end

                spd_ext = CW1'(speed_d);
                lo_lim  = MIN_X_E + spd_ext;
                sum_r   = x_ext + spd_ext;
                if (dir_now == 2'b01) begin
                    if (x_ext < lo_lim) begin
`ifdef PLAYER_WRAP_EN
                        x_d = COORD_W'(MAX_X_E - (lo_lim - CW1'(1) - x_ext));
`else
                        x_d = COORD_W'(MIN_X_E);
`endif
                    end else begin
                        x_d = COORD_W'(x_ext - spd_ext);
                    end
                end else if (dir_now == 2'b10) begin
                    if (sum_r > MAX_X_E) begin
`ifdef PLAYER_WRAP_EN
                        x_d = COORD_W'(MIN_X_E + (sum_r - MAX_X_E - CW1'(1)));
`else
                        x_d = COORD_W'(MAX_X_E);
`endif
                    end else begin
                        x_d = COORD_W'(sum_r);
                    end
                end
            end

            case (state_q)
                ST_ALIVE: begin
                    if (hit_pend_q) begin
                        lives_d = lives_q - LIVES_W'(1);
                        if (lives_d == '0) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d = ST_DYING;
                            timer_d = DEATH_C;
                        end
                    end
                end
                ST_DYING: begin
                    if (timer_q == '0) begin
                        state_d = ST_RESPAWN;
                        x_d     = START_X_C;
                        speed_d = STEP_MIN_C;
                        hold_d  = '0;
                        dir_d   = 2'b00;
                        timer_d = INVULN_C;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                ST_RESPAWN: begin
                    if (timer_q == '0) begin
                        state_d = ST_ALIVE;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign player_x   = x_q;
    assign player_y   = COORD_W'(START_Y);
    assign fire_pulse = fire_pulse_q;
    assign lives      = lives_q;
    assign alive      = can_act;
    assign visible    = (state_q == ST_DYING)   ? 1'b0 :
                        (state_q == ST_RESPAWN) ? timer_q[2] : 1'b1;
    assign game_over  = (state_q == ST_GAME_OVER);
    assign dbg_state  = state_q;

endmodule
